// File: rtl/seven_seg_pkg.sv
// Shared types and glyph helpers for the multiplexed 7-segment display controller.
// Segment patterns are active low, bit 0 = CA ... bit 6 = CG.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CONVERT = 2'd2,
        ST_COMMIT  = 2'd3
    } state_e;

    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seven_seg_display_ctrl_if.sv
// Value/mode input bus of the display controller, plus the FSM state for observation.
interface seven_seg_display_ctrl_if
    import seven_seg_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
) ();
    // A transfer happens on a rising edge with data_valid && data_ready; the value and
    // all mode bits are captured then. data_valid while data_ready is low is ignored.
    logic                  data_valid;
    logic                  data_ready;
    logic [DATA_W-1:0]     data_in;
    logic                  hex_mode;
    logic                  signed_mode;
    logic                  blank_lz;
    logic [NUM_DIGITS-1:0] dp_in;
    logic [3:0]            brightness;
    state_e                dbg_state;

    modport master (
        output data_valid, data_in, hex_mode, signed_mode, blank_lz, dp_in, brightness,
        input  data_ready, dbg_state
    );

    modport slave (
        input  data_valid, data_in, hex_mode, signed_mode, blank_lz, dp_in, brightness,
        output data_ready, dbg_state
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one magnitude bit per cycle, DATA_W cycles after start.
// done is high during the cycle whose closing edge performs the final shift.
module bin2bcd_seq #(
    parameter int DATA_W = 16,
    parameter int BCD_D  = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_W-1:0]    bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*BCD_D-1:0]   bcd
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]  sh_q, sh_d;
    logic [4*BCD_D-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        adj   = bcd_q;
        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        // The register is cleared on start, so the correction before the first shift is a no-op.
        for (int i = 0; i < BCD_D; i++) begin
            if (bcd_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        if (start) begin
            sh_d  = bin;
            bcd_d = '0;
            cnt_d = CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            bcd_d = {adj[4*BCD_D-2:0], sh_q[DATA_W-1]};
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;
endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Multi-digit common-anode 7-segment controller: accepts a value, converts it, commits it
// atomically to a display register and time-multiplexes the digits with PWM brightness.
module seven_seg_display_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 16,
    parameter int REFRESH_W  = 17
) (
    input  logic                    clk,
    input  logic                    reset_n,
    seven_seg_display_ctrl_if.slave bus,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);
    localparam int BCD_D = (DATA_W + 2) / 3;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PAD_W = 64;

    state_e state_q, state_d;

    logic [DATA_W-1:0]       cap_data_q;
    logic                    cap_hex_q, cap_sgn_q, cap_blz_q;
    logic [NUM_DIGITS-1:0]   cap_dp_q;

    logic [4*NUM_DIGITS-1:0] val_q;
    logic                    neg_q, ovf_q, blz_q;
    logic [NUM_DIGITS-1:0]   dpr_q;

    logic [REFRESH_W-1:0]    cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    accept, neg_in, cvt_start, cvt_busy, cvt_done, commit_ovf;
    logic [DATA_W-1:0]       mag;
    logic [4*BCD_D-1:0]      cvt_bcd;
    logic [PAD_W-1:0]        src_pad;

    assign accept         = (state_q == ST_IDLE) && bus.data_valid;
    assign bus.data_ready = (state_q == ST_IDLE);
    assign bus.dbg_state  = state_q;

    // Sign handling is decimal only; the magnitude stays unsigned so the most negative input does not wrap.
    assign neg_in    = cap_sgn_q && !cap_hex_q && cap_data_q[DATA_W-1];
    assign mag       = neg_in ? (~cap_data_q + 1'b1) : cap_data_q;
    assign cvt_start = (state_q == ST_LOAD) && !cap_hex_q && !cvt_busy;

    bin2bcd_seq #(.DATA_W(DATA_W), .BCD_D(BCD_D)) u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (cvt_start),
        .bin     (mag),
        .busy    (cvt_busy),
        .done    (cvt_done),
        .bcd     (cvt_bcd)
    );

    assign src_pad    = cap_hex_q ? PAD_W'(cap_data_q) : PAD_W'(cvt_bcd);
    assign commit_ovf = ((src_pad >> (4 * NUM_DIGITS)) != '0) ||
                        (neg_in && (src_pad[4*NUM_DIGITS-4 +: 4] != 4'd0));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.data_valid) state_d = ST_LOAD;
            ST_LOAD:    state_d = cap_hex_q ? ST_COMMIT : ST_CONVERT;
            ST_CONVERT: if (cvt_done) state_d = ST_COMMIT;
            ST_COMMIT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cap_data_q <= '0;
            cap_hex_q  <= 1'b0;
            cap_sgn_q  <= 1'b0;
            cap_blz_q  <= 1'b0;
            cap_dp_q   <= '0;
            val_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            blz_q      <= 1'b0;
            dpr_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cap_data_q <= bus.data_in;
                cap_hex_q  <= bus.hex_mode;
                cap_sgn_q  <= bus.signed_mode;
                cap_blz_q  <= bus.blank_lz;
                cap_dp_q   <= bus.dp_in;
            end
            if (state_q == ST_COMMIT) begin
                val_q <= src_pad[4*NUM_DIGITS-1:0];
                neg_q <= neg_in;
                ovf_q <= commit_ovf;
                blz_q <= cap_blz_q;
                dpr_q <= cap_dp_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Glyph precedence: overflow, then sign, then leading-zero blanking, then the digit itself.
    always_comb begin
        seg_d = hex_to_seg(val_q[4*idx_q +: 4]);
        if (ovf_q) seg_d = GLYPH_DASH;
        else if (neg_q && idx_q == IDX_W'(NUM_DIGITS - 1)) seg_d = GLYPH_DASH;
        else if (blz_q && idx_q != '0 && (val_q >> (4 * idx_q)) == '0) seg_d = GLYPH_BLANK;
        dp_d = ovf_q | ~dpr_q[idx_q];
        an_d = '1;
        if (cnt_q[REFRESH_W-1 -: 4] <= bus.brightness) an_d[idx_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q <= GLYPH_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;
endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Bench for seven_seg_display_ctrl: arithmetic display model with a per-cycle compare,
// plus directed vectors checked against hand-derived glyphs.
module tb_seven_seg_display_ctrl;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int RW   = 6;
    localparam int SLOT = 64;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'h7F;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;

    seven_seg_display_ctrl_if #(.DATA_W(DW), .NUM_DIGITS(N)) bus ();

    seven_seg_display_ctrl #(.NUM_DIGITS(N), .DATA_W(DW), .REFRESH_W(RW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- display model ----------------
    // Display image packed as {dp[3:0], seg3, seg2, seg1, seg0}; the queue holds accepted
    // but not yet committed images.
    logic [31:0] exp_q[$];
    logic [31:0] m_disp;
    int          m_cnt, m_idx, m_busy;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [N-1:0] e_an;

    function automatic logic [6:0] tb_glyph(input int v);
        logic [6:0] t [16];
        t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
        t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
        t[8] = 7'b0000000; t[9] = 7'b0010000; t[10] = 7'b0001000; t[11] = 7'b0000011;
        t[12] = 7'b1000110; t[13] = 7'b0100001; t[14] = 7'b0000110; t[15] = 7'b0001110;
        return t[v];
    endfunction

    function automatic logic [31:0] model_image(input logic [15:0] d, input logic h, input logic s,
                                                input logic b, input logic [3:0] dpv);
        logic [31:0] img;
        longint mag, pw;
        int base, dig;
        bit neg, ovf;
        img  = '0;
        base = h ? 16 : 10;
        neg  = !h && s && d[15];
        mag  = neg ? (longint'(65536) - longint'(d)) : longint'(d);
        pw   = 1;
        for (int k = 0; k < N; k++) pw = pw * base;
        ovf = (mag >= pw) || (neg && mag >= pw / base);
        pw  = 1;
        for (int k = 0; k < N; k++) begin
            dig = int'((mag / pw) % base);
            if (ovf) img[7*k +: 7] = DASH;
            else if (neg && k == N - 1) img[7*k +: 7] = DASH;
            else if (b && k > 0 && mag < pw) img[7*k +: 7] = BLANK;
            else img[7*k +: 7] = tb_glyph(dig);
            img[28 + k] = ovf ? 1'b1 : !dpv[k];
            pw = pw * base;
        end
        return img;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_idx  = 0;
        m_busy = 0;
        m_disp = {4'b1111, {4{7'b1000000}}};
        e_seg  = BLANK;
        e_dp   = 1'b1;
        e_an   = '1;
        exp_q.delete();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                e_seg = m_disp[7*m_idx +: 7];
                e_dp  = m_disp[28 + m_idx];
                e_an  = ((m_cnt / (SLOT / 16)) <= int'(bus.brightness)) ? N'(~(4'b0001 << m_idx)) : '1;
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0 && exp_q.size() > 0) m_disp = exp_q.pop_front();
                end else if (bus.data_valid) begin
                    m_busy = bus.hex_mode ? 2 : DW + 2;
                    exp_q.push_back(model_image(bus.data_in, bus.hex_mode, bus.signed_mode,
                                                bus.blank_lz, bus.dp_in));
                end
                m_cnt++;
                if (m_cnt == SLOT) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % N;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_seg", seg, e_seg);
            chk("cyc_dp", dp, e_dp);
            chk("cyc_an", an, e_an);
            chk("cyc_ready", bus.data_ready, (m_busy == 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] d, input logic h, input logic s, input logic b,
                        input logic [3:0] dpv, output int lat);
        int g;
        @(negedge clk);
        bus.data_in     = d;
        bus.hex_mode    = h;
        bus.signed_mode = s;
        bus.blank_lz    = b;
        bus.dp_in       = dpv;
        bus.data_valid  = 1'b1;
        g = 0;
        while (!bus.data_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        bus.data_valid = 1'b0;
        lat = 0;
        while (!bus.data_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_digit(input int k, input logic [6:0] es, input logic ed);
        int g;
        logic [N-1:0] want;
        want = N'(~(4'b0001 << k));
        g = 0;
        @(negedge clk);
        while (an !== want && g < 3 * N * SLOT) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("an_digit%0d", k), an, want);
        chk($sformatf("seg_digit%0d", k), seg, es);
        chk($sformatf("dp_digit%0d", k), dp, ed);
    endtask

    task automatic count_on(input logic [3:0] br, output int n);
        @(negedge clk);
        bus.brightness = br;
        repeat (2) @(negedge clk);
        n = 0;
        for (int i = 0; i < SLOT; i++) begin
            @(negedge clk);
            if (an != '1) n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, n, g;
        bus.data_valid  = 1'b0;
        bus.data_in     = '0;
        bus.hex_mode    = 1'b0;
        bus.signed_mode = 1'b0;
        bus.blank_lz    = 1'b0;
        bus.dp_in       = '0;
        bus.brightness  = 4'd15;

        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'hF);
        chk("rst_dp", dp, 1'b1);
        chk("rst_state", bus.dbg_state, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.data_ready, 1'b1);

        // unsigned decimal with one decimal point
        send(16'd1234, 1'b0, 1'b0, 1'b0, 4'b0100, lat);
        chk("lat_dec", lat, 18);
        check_digit(0, 7'b0011001, 1'b1);
        check_digit(1, 7'b0110000, 1'b1);
        check_digit(2, 7'b0100100, 1'b0);
        check_digit(3, 7'b1111001, 1'b1);

        // signed with blanking, then most-negative value overflows
        send(16'hFFF9, 1'b0, 1'b1, 1'b1, 4'b0000, lat);
        check_digit(0, 7'b1111000, 1'b1);
        check_digit(1, BLANK, 1'b1);
        check_digit(2, BLANK, 1'b1);
        check_digit(3, DASH, 1'b1);
        send(16'h8000, 1'b0, 1'b1, 1'b0, 4'b1111, lat);
        check_digit(0, DASH, 1'b1);
        check_digit(3, DASH, 1'b1);

        // five decimal digits on four positions
        send(16'd12345, 1'b0, 1'b0, 1'b0, 4'b0000, lat);
        check_digit(1, DASH, 1'b1);

        // hex mode, signed ignored
        send(16'hBEEF, 1'b1, 1'b1, 1'b0, 4'b1111, lat);
        chk("lat_hex", lat, 2);
        check_digit(0, 7'b0001110, 1'b0);
        check_digit(1, 7'b0000110, 1'b0);
        check_digit(2, 7'b0000110, 1'b0);
        check_digit(3, 7'b0000011, 1'b0);
        send(16'h00A5, 1'b1, 1'b0, 1'b1, 4'b0000, lat);
        check_digit(0, 7'b0010010, 1'b1);
        check_digit(1, 7'b0001000, 1'b1);
        check_digit(2, BLANK, 1'b1);
        check_digit(3, BLANK, 1'b1);

        // data_valid held high across two values
        @(negedge clk);
        bus.hex_mode    = 1'b0;
        bus.signed_mode = 1'b0;
        bus.blank_lz    = 1'b0;
        bus.dp_in       = '0;
        bus.data_in     = 16'd100;
        bus.data_valid  = 1'b1;
        @(negedge clk);
        bus.data_in = 16'd200;
        g = 0;
        while (!bus.data_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("hs_wait", (g < 100), 1'b1);
        @(negedge clk);
        bus.data_valid = 1'b0;
        g = 0;
        while (!bus.data_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check_digit(2, 7'b0100100, 1'b1);
        check_digit(1, 7'b1000000, 1'b1);

        // brightness duty
        count_on(4'd0, n);
        chk("bright0_on", n, 4);
        count_on(4'd7, n);
        chk("bright7_on", n, 32);
        count_on(4'd15, n);
        chk("bright15_on", n, 64);

        // reset in the middle of a conversion
        @(negedge clk);
        bus.data_in    = 16'd999;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_seg", seg, 7'h7F);
        chk("midrst_an", an, 4'hF);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", bus.data_ready, 1'b1);
        check_digit(0, 7'b1000000, 1'b1);
        check_digit(3, 7'b1000000, 1'b1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seven_seg_display_ctrl.md
Name: seven_seg_display_ctrl

Overview:
- Parametrised multi-digit 7-segment display controller for the board display path.
- Accepts a binary value through a valid/ready handshake and converts it to BCD sequentially with a shift-add-3 engine, one bit per cycle.
- Multiplexes NUM_DIGITS common-anode digits and adds:
  - hex mode
  - signed mode
  - leading-zero blanking
  - per-digit decimal points
  - overflow indication
  - PWM brightness
- The displayed value changes only atomically, after conversion completes.

Parameters:
- NUM_DIGITS, 4, number of digits driven (legal range 1..8).
- DATA_W, 16, width of the binary input (legal range 4..32).
- REFRESH_W, 17, width of the refresh counter; the digit slot is 2^REFRESH_W cycles (minimum 6).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- data_valid  in  1  new value offered
- data_ready  out  1  controller can accept; high only in IDLE
- data_in  in  DATA_W  binary value
- hex_mode  in  1  1 = display hex nibbles, 0 = decimal; sampled at accept
- signed_mode  in  1  1 = data_in is two's complement; decimal only; sampled at accept
- blank_lz  in  1  blank leading zeros; sampled at accept
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit; sampled at accept
- brightness  in  4  duty control; live, not sampled
- seg  out  7  segments CA..CG, active low, registered
- dp  out  1  decimal point, active low, registered
- an  out  NUM_DIGITS  digit enables, active low, registered; an[0] = rightmost digit

Behaviour:
- Reset (async assert, sync deassert):
  - FSM goes to IDLE.
  - Display register cleared: value 0, neg=0, ovf=0, dp=0, blank_lz=0.
  - Refresh counter = 0, digit index = 0.
  - seg = 7'h7F, dp = 1, an = all ones.
  - data_ready = 1 on the first cycle after deassert.
- Accept: data_valid && data_ready on a rising edge captures data_in and all mode inputs. data_valid while data_ready = 0 is ignored, with no queuing.
- FSM states: IDLE, LOAD, CONVERT, COMMIT.
  - IDLE -> LOAD on accept.
  - LOAD:
    - Computes the magnitude. If signed_mode and data_in[DATA_W-1] = 1, magnitude = two's complement of data_in and neg = 1.
    - Next state is COMMIT when hex_mode, otherwise CONVERT.
  - CONVERT:
    - Runs exactly DATA_W cycles.
    - Each cycle, every BCD digit > 4 gets +3, then a left shift with the next magnitude bit.
    - The add-3 step is skipped before the first shift.
  - COMMIT:
    - Loads the display register in one cycle, then returns to IDLE.
- Latency, accept edge to new display register:
  - decimal = DATA_W + 2 cycles
  - hex = 2 cycles
  - data_ready is low for the same span.
- Internal BCD width: BCD_D = (DATA_W + 2) / 3 digits.
  - ovf = 1 when any BCD digit at index >= NUM_DIGITS is nonzero.
  - ovf = 1 also when neg = 1 and digit NUM_DIGITS-1 is nonzero.
  - The sign occupies the leftmost digit.
- Hex mode:
  - Digit k shows nibble k.
  - ovf = 1 when any nibble at index >= NUM_DIGITS is nonzero.
  - signed_mode is ignored.
- Most-negative input, e.g. 16'h8000: magnitude 32768, no wrap; the magnitude register is DATA_W bits unsigned.
- Refresh:
  - The counter free-runs.
  - The digit index increments when the counter wraps to 0.
  - The digit index wraps from NUM_DIGITS-1 to 0, including non-power-of-two counts.
- Brightness:
  - The selected anode is active while counter[REFRESH_W-1 -: 4] <= brightness.
  - brightness 15 = always on; brightness 0 = 1/16 duty.
  - All anodes are high otherwise.
- Glyphs:
  - Digits 0-9 and A-F use the standard glyphs (A, b, C, d, E, F).
  - Dash = 7'b0111111; blank = 7'h7F.
  - Glyph precedence, highest first:
    - ovf: every digit dash, dp off.
    - neg: leftmost digit dash.
    - Leading-zero blanking (blank_lz=1): digits above the most significant nonzero digit show blank; digit 0 is never blanked.
    - Otherwise the digit value.
  - dp = ~dp_reg[index] unless ovf.
- Outputs are registered; they change one cycle after the digit index or the display register changes.
- Reset mid-conversion aborts the conversion and clears the display register; no partial value is ever displayed.

Decomposition:
- seven_seg_pkg:
  - state enum typedef
  - glyph constants (GLYPH_DASH, GLYPH_BLANK)
  - function hex_to_seg(4-bit) -> 7-bit active-low pattern
- Sub-module bin2bcd_seq:
  - Parameters: DATA_W, BCD_D.
  - Ports: clk, reset_n, start, bin, busy, done, bcd.
  - Sequential double dabble.
  - The top FSM drives it from LOAD and waits for done.

Test Plan:
- Unsigned decimal, DATA_W=16, NUM_DIGITS=4, REFRESH_W=6, brightness=15, data_in=1234 -> data_ready low 18 cycles; then digits 3..0 show 1,2,3,4 (seg 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001) with an cycling 1110, 1101, 1011, 0111 every 64 cycles.
- Signed and blanking, signed_mode=1, blank_lz=1, data_in=16'hFFF9 -> digit 3 dash, digits 2..1 blank, digit 0 shows 7; second value 16'h8000 -> all four digits dash (ovf).
- Overflow and hex:
  - decimal 12345 on 4 digits -> all dashes.
  - hex_mode=1, data_in=16'hBEEF -> b, E, E, F after 2 cycles.
- Handshake: data_valid held high across two values -> only the value at the ready edge is captured; the display shows the old value until COMMIT, then the new one.
- Brightness 0 -> anode low only when counter top nibble = 0 (4 of 64 cycles per slot); brightness 7 -> 32 of 64.
- Reset: assert reset_n low mid-CONVERT -> next cycle seg=7'h7F, an=all ones; after release digit 0 shows 0 and data_ready=1.
